// File: rtl/img_lut_loader.sv
// img_lut_loader: frame-synchronous loader for the pixel LUT.
// A software start arms the loader; on the next start-of-frame the video
// stream is held at the frame boundary while a complete table is streamed
// into the LUT write port. Video is then released, so no frame is ever
// mapped through a partially updated table.
module img_lut_loader #(
    parameter int PX_WIDTH    = 10,
    parameter int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    // Software control
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,

    // Table stream: LUT entries in address order
    input  logic                     table_tvalid_i,
    output logic                     table_tready_o,
    input  logic [TDATA_WIDTH-1:0]   table_tdata_i,
    input  logic                     table_tlast_i,

    // LUT write-control port
    output logic [PX_WIDTH-1:0]      lut_orig_px_o,
    output logic [PX_WIDTH-1:0]      lut_mod_px_o,
    output logic                     lut_wr_stb_o,

    // Upstream video
    input  logic                     video_in_tvalid_i,
    output logic                     video_in_tready_o,
    input  logic [TDATA_WIDTH-1:0]   video_in_tdata_i,
    input  logic                     video_in_tlast_i,
    input  logic                     video_in_tuser_i,
    input  logic [TDATA_WIDTH/8-1:0] video_in_tstrb_i,
    input  logic [TDATA_WIDTH/8-1:0] video_in_tkeep_i,
    input  logic [TID_WIDTH-1:0]     video_in_tid_i,
    input  logic [TDEST_WIDTH-1:0]   video_in_tdest_i,

    // Video toward the LUT
    output logic                     video_out_tvalid_o,
    input  logic                     video_out_tready_i,
    output logic [TDATA_WIDTH-1:0]   video_out_tdata_o,
    output logic                     video_out_tlast_o,
    output logic                     video_out_tuser_o,
    output logic [TDATA_WIDTH/8-1:0] video_out_tstrb_o,
    output logic [TDATA_WIDTH/8-1:0] video_out_tkeep_o,
    output logic [TID_WIDTH-1:0]     video_out_tid_o,
    output logic [TDEST_WIDTH-1:0]   video_out_tdest_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    localparam logic [PX_WIDTH-1:0] LAST_ADDR = {PX_WIDTH{1'b1}};

    state_t              state_q, state_d;
    logic [PX_WIDTH-1:0] addr_q, addr_d;
    logic [PX_WIDTH-1:0] orig_q, orig_d;
    logic [PX_WIDTH-1:0] mod_q, mod_d;
    logic                wr_stb_q, wr_stb_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                sof_seen;
    logic                tbl_acc;
    logic                last_entry;
    logic                gate;

    // Only the low PX_WIDTH bits of a table beat carry the LUT entry; the
    // byte-padding bits above them are don't-care.
    logic                unused_tdata_pad;
    assign unused_tdata_pad = ^(table_tdata_i >> PX_WIDTH);

    assign sof_seen       = video_in_tvalid_i && video_in_tuser_i;
    assign table_tready_o = (state_q == ST_LOAD);
    assign tbl_acc        = table_tvalid_i && table_tready_o;
    assign last_entry     = (addr_q == LAST_ADDR);

    // The SOF beat is held from the very cycle it appears while armed, so
    // the LUT never sees a pixel of the new frame before the table is whole.
    assign gate = (state_q == ST_LOAD) || (state_q == ST_FLUSH) ||
                  ((state_q == ST_ARMED) && sof_seen);

    // Next-state and write-port logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        orig_d   = orig_q;
        mod_d    = mod_q;
        wr_stb_d = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ARMED;
                    err_d   = 1'b0;
                end
            end

            ST_ARMED: begin
                if (sof_seen) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end

            ST_LOAD: begin
                if (tbl_acc) begin
                    wr_stb_d = 1'b1;
                    orig_d   = addr_q;
                    mod_d    = table_tdata_i[PX_WIDTH-1:0];
                    // tlast must coincide exactly with the final entry; the
                    // load itself always completes by count regardless.
                    if (table_tlast_i != last_entry) begin
                        err_d = 1'b1;
                    end
                    if (last_entry) begin
                        state_d = ST_FLUSH;
                    end else begin
                        addr_d = addr_q + PX_WIDTH'(1);
                    end
                end
            end

            ST_FLUSH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and write-port registers; reset aborts any load in progress
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            orig_q   <= '0;
            mod_q    <= '0;
            wr_stb_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            orig_q   <= orig_d;
            mod_q    <= mod_d;
            wr_stb_q <= wr_stb_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

    assign lut_orig_px_o = orig_q;
    assign lut_mod_px_o  = mod_q;
    assign lut_wr_stb_o  = wr_stb_q;

    // Video pass-through; only the handshake is gated.
    assign video_out_tvalid_o = video_in_tvalid_i && !gate;
    assign video_in_tready_o  = video_out_tready_i && !gate;
    assign video_out_tdata_o  = video_in_tdata_i;
    assign video_out_tlast_o  = video_in_tlast_i;
    assign video_out_tuser_o  = video_in_tuser_i;
    assign video_out_tstrb_o  = video_in_tstrb_i;
    assign video_out_tkeep_o  = video_in_tkeep_i;
    assign video_out_tid_o    = video_in_tid_i;
    assign video_out_tdest_o  = video_in_tdest_i;

endmodule
